// File: rtl/mem_stage_if.sv
// mem_stage_if: upstream, memory and write-back signals of the MIPS memory-access stage.
// MEM_STAGE_MISALIGN_TRAP_EN adds the misalign trap signal.
interface mem_stage_if;
  logic        insn_valid;
  logic [0:31] insn;
  logic [0:31] alu_result;
  logic [0:31] rt_data;
  logic [0:31] pc;
  logic [0:31] mem_address;
  logic        mem_wren;
  logic [0:31] mem_data_in;
  logic [0:31] mem_data_out;
  logic        stall;
  logic        wb_valid;
  logic        wb_write_enable;
  logic [4:0]  wb_rd;
  logic [0:31] wb_data;
  logic [0:31] pc_out;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic        misalign;

  modport master (
    output insn_valid, insn, alu_result, rt_data, pc, mem_data_out,
    input  mem_address, mem_wren, mem_data_in, stall,
    input  wb_valid, wb_write_enable, wb_rd, wb_data, pc_out, misalign
  );
  modport slave (
    input  insn_valid, insn, alu_result, rt_data, pc, mem_data_out,
    output mem_address, mem_wren, mem_data_in, stall,
    output wb_valid, wb_write_enable, wb_rd, wb_data, pc_out, misalign
  );
`else
  modport master (
    output insn_valid, insn, alu_result, rt_data, pc, mem_data_out,
    input  mem_address, mem_wren, mem_data_in, stall,
    input  wb_valid, wb_write_enable, wb_rd, wb_data, pc_out
  );
  modport slave (
    input  insn_valid, insn, alu_result, rt_data, pc, mem_data_out,
    output mem_address, mem_wren, mem_data_in, stall,
    output wb_valid, wb_write_enable, wb_rd, wb_data, pc_out
  );
`endif
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage (loads, stores with sub-word read-modify-write, write-back).
// Define MEM_STAGE_MISALIGN_TRAP_EN to trap misaligned word/halfword accesses instead of truncating.
module mem_stage #(
  parameter logic [4:0] LINK_REG    = 5'd31,
  parameter bit         SUPPRESS_R0 = 1'b1
) (
  input logic        clock,
  input logic        reset,
  mem_stage_if.slave bus
);
  localparam int unsigned W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RMW_WR = 2'd2} state_t;
  state_t state, state_n;

  logic [5:0]   op, funct;
  logic [4:0]   rt, rd;
  logic [0:W-1] aligned;
  logic         misaligned;
  logic [5:0]   op_q;
  logic [1:0]   off_q;
  logic [0:W-1] addr_q, pc_q;
  logic [15:0]  st_q;
  logic [4:0]   rt_q;
  logic         capture, retire_n, we_n;
  logic [4:0]   rd_n;
  logic [0:W-1] data_n, pc_n;
  logic         unused_bits;

  assign op          = bus.insn[0:5];
  assign rt          = bus.insn[11:15];
  assign rd          = bus.insn[16:20];
  assign funct       = bus.insn[26:31];
  assign aligned     = {bus.alu_result[0:29], 2'b00};
  assign unused_bits = ^{bus.insn[6:10], bus.insn[21:25]};

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign misaligned = (((op == OP_LW) || (op == OP_SW)) && (bus.alu_result[30:31] != 2'b00)) ||
                      (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && bus.alu_result[31]);
`else
  assign misaligned = 1'b0;
`endif

  // Big-endian lane extraction: byte offset 0 is bits [0:7].
  function automatic logic [0:W-1] load_lane(input logic [5:0] op_i, input logic [1:0] off,
                                             input logic [0:W-1] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[0:7];
      2'd1:    b = word[8:15];
      2'd2:    b = word[16:23];
      default: b = word[24:31];
    endcase
    h = off[1] ? word[16:31] : word[0:15];
    case (op_i)
      OP_LB:   load_lane = {{24{b[7]}}, b};
      OP_LBU:  load_lane = {24'd0, b};
      OP_LH:   load_lane = {{16{h[15]}}, h};
      OP_LHU:  load_lane = {16'd0, h};
      default: load_lane = word;
    endcase
  endfunction

  function automatic logic [0:W-1] merge_lane(input logic [5:0] op_i, input logic [1:0] off,
                                              input logic [0:W-1] word, input logic [15:0] st);
    logic [0:W-1] w;
    w = word;
    if (op_i == OP_SH) begin
      if (off[1]) w[16:31] = st;
      else        w[0:15]  = st;
    end else begin
      case (off)
        2'd0:    w[0:7]   = st[7:0];
        2'd1:    w[8:15]  = st[7:0];
        2'd2:    w[16:23] = st[7:0];
        default: w[24:31] = st[7:0];
      endcase
    end
    merge_lane = w;
  endfunction

  // Next state, memory strobes and next write-back values.
  always_comb begin
    state_n         = state;
    bus.mem_address = '0;
    bus.mem_wren    = 1'b0;
    bus.mem_data_in = '0;
    bus.stall       = 1'b0;
    capture         = 1'b0;
    retire_n        = 1'b0;
    we_n            = 1'b0;
    rd_n            = bus.wb_rd;
    data_n          = bus.wb_data;
    pc_n            = bus.pc_out;
    case (state)
      IDLE: begin
        if (bus.insn_valid) begin
          if (misaligned) begin
            retire_n = 1'b1;
            pc_n     = bus.pc;
          end else begin
            case (op)
              OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                bus.mem_address = aligned;
                bus.stall       = 1'b1;
                capture         = 1'b1;
                state_n         = LOAD;
              end
              OP_SB, OP_SH: begin
                bus.mem_address = aligned;
                bus.stall       = 1'b1;
                capture         = 1'b1;
                state_n         = RMW_WR;
              end
              OP_SW: begin
                bus.mem_address = aligned;
                bus.mem_wren    = 1'b1;
                bus.mem_data_in = bus.rt_data;
                retire_n        = 1'b1;
                pc_n            = bus.pc;
              end
              OP_RTYPE: begin
                retire_n = 1'b1;
                pc_n     = bus.pc;
                if (funct != FN_JR) begin
                  we_n   = 1'b1;
                  rd_n   = rd;
                  data_n = bus.alu_result;
                end
              end
              OP_JAL: begin
                retire_n = 1'b1;
                pc_n     = bus.pc;
                we_n     = 1'b1;
                rd_n     = LINK_REG;
                data_n   = bus.pc + W'(8);
              end
              default: begin
                retire_n = 1'b1;
                pc_n     = bus.pc;
                // Immediate ALU group 0x08-0x0F writes rt; everything else retires silently.
                if (op[5:3] == 3'b001) begin
                  we_n   = 1'b1;
                  rd_n   = rt;
                  data_n = bus.alu_result;
                end
              end
            endcase
          end
        end
      end
      LOAD: begin
        bus.mem_address = addr_q;
        retire_n        = 1'b1;
        we_n            = 1'b1;
        rd_n            = rt_q;
        data_n          = load_lane(op_q, off_q, bus.mem_data_out);
        pc_n            = pc_q;
        state_n         = IDLE;
      end
      RMW_WR: begin
        bus.mem_address = addr_q;
        bus.mem_wren    = 1'b1;
        bus.mem_data_in = merge_lane(op_q, off_q, bus.mem_data_out, st_q);
        retire_n        = 1'b1;
        pc_n            = pc_q;
        state_n         = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A write must never leak out while reset is asserted.
    if (reset) begin
      bus.mem_address = '0;
      bus.mem_wren    = 1'b0;
      bus.mem_data_in = '0;
      bus.stall       = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      op_q                <= '0;
      off_q               <= '0;
      addr_q              <= '0;
      st_q                <= '0;
      rt_q                <= '0;
      pc_q                <= '0;
      bus.wb_valid        <= 1'b0;
      bus.wb_write_enable <= 1'b0;
      bus.wb_rd           <= '0;
      bus.wb_data         <= '0;
      bus.pc_out          <= '0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      bus.misalign        <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (capture) begin
        op_q   <= op;
        off_q  <= bus.alu_result[30:31];
        addr_q <= aligned;
        st_q   <= bus.rt_data[16:31];
        rt_q   <= rt;
        pc_q   <= bus.pc;
      end
      bus.wb_valid        <= retire_n;
      bus.wb_write_enable <= we_n && !(SUPPRESS_R0 && (rd_n == 5'd0));
      bus.wb_rd           <= rd_n;
      bus.wb_data         <= data_n;
      bus.pc_out          <= pc_n;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      bus.misalign        <= (state == IDLE) && bus.insn_valid && misaligned;
`endif
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a byte-level reference model.
// Honours MEM_STAGE_MISALIGN_TRAP_EN the same way as the design.
module tb_mem_stage;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic preload = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   wr_cnt = 0;

  bit [0:31] mem  [64];
  bit [0:31] mmem [64];

  localparam bit [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam bit [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;

  mem_stage_if bus();

  mem_stage #(.LINK_REG(5'd31), .SUPPRESS_R0(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous-read word memory; preload mirrors the reference image into it.
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= mmem[i];
    end else if (bus.mem_wren) begin
      mem[bus.mem_address[24:29]] <= bus.mem_data_in;
      wr_cnt <= wr_cnt + 1;
    end
    bus.mem_data_out <= mem[bus.mem_address[24:29]];
  end

  function automatic bit [0:31] mk(input bit [5:0] op, input bit [4:0] rt, input bit [4:0] rd,
                                   input bit [5:0] fn);
    mk = {op, 5'd0, rt, rd, 5'd0, fn};
  endfunction

  // Reference semantics in plain arithmetic over a word array; updates mmem for stores.
  function automatic void model(input bit [0:31] insn, input bit [0:31] alu, input bit [0:31] rtd,
                                input bit [0:31] pc, output bit we, output bit [4:0] rd,
                                output bit [0:31] data, output bit multi, output int writes,
                                output bit mis);
    int unsigned op  = insn[0:5];
    int unsigned rtf = insn[11:15];
    int unsigned rdf = insn[16:20];
    int unsigned fn  = insn[26:31];
    int unsigned a   = alu;
    int unsigned idx = (a >> 2) & 63;
    int unsigned off = a & 3;
    int unsigned w   = mmem[idx];
    int unsigned sh, v;
    we = 0; rd = 0; data = 0; multi = 0; writes = 0; mis = 0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    mis = ((op == 'h23 || op == 'h2B) && off != 0) ||
          ((op == 'h21 || op == 'h25 || op == 'h29) && (off & 1) != 0);
`endif
    if (mis) return;
    case (op)
      'h20, 'h24: begin
        sh = 24 - 8 * off; v = (w >> sh) & 'hFF;
        if (op == 'h20 && v >= 'h80) v = v | 'hFFFF_FF00;
        rd = 5'(rtf); data = v; multi = 1;
      end
      'h21, 'h25: begin
        sh = (off >= 2) ? 0 : 16; v = (w >> sh) & 'hFFFF;
        if (op == 'h21 && v >= 'h8000) v = v | 'hFFFF_0000;
        rd = 5'(rtf); data = v; multi = 1;
      end
      'h23: begin rd = 5'(rtf); data = w; multi = 1; end
      'h2B: begin mmem[idx] = rtd; writes = 1; end
      'h28: begin
        sh = 24 - 8 * off;
        mmem[idx] = (w & ~(32'hFF << sh)) | ((rtd & 'hFF) << sh);
        writes = 1; multi = 1;
      end
      'h29: begin
        sh = (off >= 2) ? 0 : 16;
        mmem[idx] = (w & ~(32'hFFFF << sh)) | ((rtd & 'hFFFF) << sh);
        writes = 1; multi = 1;
      end
      'h00: if (fn != 8) begin rd = 5'(rdf); data = alu; end
      'h03: begin rd = 5'd31; data = pc + 8; end
      default: if (op >= 8 && op <= 15) begin rd = 5'(rtf); data = alu; end
    endcase
    we = (op == 'h00 && fn != 8) || op == 'h03 || (op >= 8 && op <= 15) ||
         op == 'h20 || op == 'h21 || op == 'h23 || op == 'h24 || op == 'h25;
    if (rd == 0) we = 0;
  endfunction

  // Present one instruction at a negedge and hold it while the stage stalls.
  task automatic drive(input bit [0:31] i_insn, input bit [0:31] alu, input bit [0:31] rtd,
                       input bit [0:31] i_pc, output int stalls, output int wrens);
    bit s;
    bus.insn_valid = 1'b1; bus.insn = i_insn; bus.alu_result = alu;
    bus.rt_data = rtd; bus.pc = i_pc;
    #1;
    s = bus.stall;
    stalls = int'(s);
    wrens  = int'(bus.mem_wren);
    @(negedge clock);
    if (s) begin
      stalls += int'(bus.stall);
      wrens  += int'(bus.mem_wren);
      @(negedge clock);
    end
    bus.insn_valid = 1'b0;
  endtask

  task automatic load_word(input bit [0:31] addr, input bit [0:31] val);
    mmem[(addr >> 2) & 63] = val;
    preload = 1'b1;
    @(negedge clock);
    preload = 1'b0;
  endtask

  task automatic test_reset();
    bus.insn_valid = 0; bus.insn = 0; bus.alu_result = 0; bus.rt_data = 0; bus.pc = 0;
    for (int i = 0; i < 64; i++) mmem[i] = $urandom;
    repeat (2) @(negedge clock);
    vectors++;
    if ({bus.stall, bus.mem_wren, bus.wb_valid, bus.wb_write_enable} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0000", {bus.stall, bus.mem_wren, bus.wb_valid, bus.wb_write_enable});
    end
    vectors++;
    if ({bus.wb_rd, bus.wb_data, bus.pc_out, bus.mem_address, bus.mem_data_in} !== 133'd0) begin
      miscompares++;
      $display("FAIL reset_values: rd %h data %h pc %h addr %h din %h want all 0",
               bus.wb_rd, bus.wb_data, bus.pc_out, bus.mem_address, bus.mem_data_in);
    end
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    vectors++;
    if (bus.misalign !== 1'b0) begin
      miscompares++; $display("FAIL reset_misalign: got %b want 0", bus.misalign);
    end
`endif
    preload = 0; reset = 0;
    @(negedge clock);
  endtask

  task automatic test_alu();
    bit we; bit [4:0] rd; bit [0:31] d; bit multi, mis; int wr, st, wn;
    model(mk(6'h00, 5'd1, 5'd5, 6'h21), 32'h7, 0, 32'h400, we, rd, d, multi, wr, mis);
    drive(mk(6'h00, 5'd1, 5'd5, 6'h21), 32'h7, 0, 32'h400, st, wn);
    vectors++;
    if ({st, bus.wb_valid, bus.wb_write_enable, bus.wb_rd, bus.wb_data, bus.pc_out} !==
        {32'd0, 1'b1, 1'b1, 5'd5, 32'h7, 32'h400}) begin
      miscompares++;
      $display("FAIL addu: stall %0d v %b we %b rd %0d data %h pc %h want 0 1 1 5 7 400",
               st, bus.wb_valid, bus.wb_write_enable, bus.wb_rd, bus.wb_data, bus.pc_out);
    end
    drive(mk(6'h03, 5'd0, 5'd0, 6'h0), 32'hDEAD, 0, 32'h1000, st, wn);
    vectors++;
    if ({bus.wb_valid, bus.wb_write_enable, bus.wb_rd, bus.wb_data} !== {1'b1, 1'b1, 5'd31, 32'h1008}) begin
      miscompares++;
      $display("FAIL jal: v %b we %b rd %0d data %h want 1 1 31 1008",
               bus.wb_valid, bus.wb_write_enable, bus.wb_rd, bus.wb_data);
    end
    drive(mk(6'h00, 5'd1, 5'd0, 6'h21), 32'h9, 0, 32'h1004, st, wn);
    vectors++;
    if ({bus.wb_valid, bus.wb_write_enable} !== 2'b10) begin
      miscompares++; $display("FAIL r0_suppress: v/we %b want 10", {bus.wb_valid, bus.wb_write_enable});
    end
    drive(mk(6'h04, 5'd3, 5'd3, 6'h0), 32'h9, 0, 32'h1008, st, wn);
    vectors++;
    if ({bus.wb_valid, bus.wb_write_enable, bus.pc_out} !== {2'b10, 32'h1008}) begin
      miscompares++;
      $display("FAIL branch: v/we %b pc %h want 10 1008", {bus.wb_valid, bus.wb_write_enable}, bus.pc_out);
    end
  endtask

  task automatic test_loads();
    int st, wn;
    bit [0:31] exp_d [4] = '{32'hFFFF_FFF2, 32'h0000_00F2, 32'h0000_3344, 32'h0000_11F2};
    bit [5:0]  ops   [4] = '{LB, LBU, LHU, LH};
    bit [0:31] adr   [4] = '{32'h8002_0101, 32'h8002_0101, 32'h8002_0102, 32'h8002_0100};
    load_word(32'h8002_0100, 32'h11F2_3344);
    for (int i = 0; i < 4; i++) begin
      drive(mk(ops[i], 5'd9, 5'd0, 6'h0), adr[i], 0, 32'h2000 + 4 * i, st, wn);
      vectors++;
      if ({st, wn, bus.wb_valid, bus.wb_write_enable, bus.wb_rd, bus.wb_data} !==
          {32'd1, 32'd0, 1'b1, 1'b1, 5'd9, exp_d[i]}) begin
        miscompares++;
        $display("FAIL load_%0d: stall %0d wren %0d v %b we %b rd %0d data %h want 1 0 1 1 9 %h",
                 i, st, wn, bus.wb_valid, bus.wb_write_enable, bus.wb_rd, bus.wb_data, exp_d[i]);
      end
    end
  endtask

  task automatic test_store();
    bit we; bit [4:0] rd; bit [0:31] d; bit multi, mis; int wr, st, wn, w0;
    model(mk(SB, 5'd4, 5'd0, 6'h0), 32'h8002_0102, 32'h0000_00AB, 32'h3000, we, rd, d, multi, wr, mis);
    w0 = wr_cnt;
    drive(mk(SB, 5'd4, 5'd0, 6'h0), 32'h8002_0102, 32'h0000_00AB, 32'h3000, st, wn);
    vectors++;
    if ({mem[0], wn, wr_cnt - w0, bus.wb_valid, bus.wb_write_enable} !==
        {32'h11F2_AB44, 32'd1, 32'd1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL sb_rmw: word %h wren %0d writes %0d v %b we %b want 11f2ab44 1 1 1 0",
               mem[0], wn, wr_cnt - w0, bus.wb_valid, bus.wb_write_enable);
    end
    model(mk(SH, 5'd4, 5'd0, 6'h0), 32'h8002_0100, 32'h1234_BEEF, 32'h3004, we, rd, d, multi, wr, mis);
    drive(mk(SH, 5'd4, 5'd0, 6'h0), 32'h8002_0100, 32'h1234_BEEF, 32'h3004, st, wn);
    vectors++;
    if ({mem[0], st, wn} !== {32'hBEEF_AB44, 32'd1, 32'd1}) begin
      miscompares++;
      $display("FAIL sh_rmw: word %h stall %0d wren %0d want beefab44 1 1", mem[0], st, wn);
    end
  endtask

  task automatic test_back_to_back();
    bit we; bit [4:0] rd; bit [0:31] d; bit multi, mis; int wr, st, wn, n, nsw;
    load_word(32'h8002_0104, 32'h0123_4567);
    n = cyc;
    drive(mk(LW, 5'd7, 5'd0, 6'h0), 32'h8002_0104, 0, 32'h4000, st, wn);
    vectors++;
    if ({cyc - n, bus.wb_valid, bus.wb_rd, bus.wb_data} !== {32'd2, 1'b1, 5'd7, 32'h0123_4567}) begin
      miscompares++;
      $display("FAIL b2b_lw: lat %0d v %b rd %0d data %h want 2 1 7 01234567",
               cyc - n, bus.wb_valid, bus.wb_rd, bus.wb_data);
    end
    drive(mk(6'h00, 5'd1, 5'd8, 6'h21), 32'h55, 0, 32'h4004, st, wn);
    vectors++;
    if ({cyc - n, bus.wb_valid, bus.wb_rd, bus.wb_data, bus.pc_out} !== {32'd3, 1'b1, 5'd8, 32'h55, 32'h4004}) begin
      miscompares++;
      $display("FAIL b2b_addu: retire %0d v %b rd %0d data %h pc %h want 3 1 8 55 4004",
               cyc - n, bus.wb_valid, bus.wb_rd, bus.wb_data, bus.pc_out);
    end
    nsw = cyc;
    model(mk(SW, 5'd2, 5'd0, 6'h0), 32'h8002_0104, 32'h9988_7766, 32'h4008, we, rd, d, multi, wr, mis);
    drive(mk(SW, 5'd2, 5'd0, 6'h0), 32'h8002_0104, 32'h9988_7766, 32'h4008, st, wn);
    vectors++;
    if ({nsw - n, wn, st, mem[1], bus.wb_write_enable} !== {32'd3, 32'd1, 32'd0, 32'h9988_7766, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_sw: cyc %0d wren %0d stall %0d word %h we %b want 3 1 0 99887766 0",
               nsw - n, wn, st, mem[1], bus.wb_write_enable);
    end
  endtask

  task automatic test_idle();
    bit [4:0] rd0;
    bit [0:31] d0;
    rd0 = bus.wb_rd; d0 = bus.wb_data;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if ({bus.wb_valid, bus.mem_wren, bus.stall, bus.wb_rd, bus.wb_data} !== {3'b000, rd0, d0}) begin
        miscompares++;
        $display("FAIL idle_%0d: v/wren/stall %b rd %0d data %h want 000 %0d %h", i,
                 {bus.wb_valid, bus.mem_wren, bus.stall}, bus.wb_rd, bus.wb_data, rd0, d0);
      end
    end
  endtask

  task automatic test_misalign_cfg();
    bit we; bit [4:0] rd; bit [0:31] d; bit multi, mis; int wr, st, wn;
    load_word(32'h8002_0100, 32'h11F2_3344);
    model(mk(LW, 5'd6, 5'd0, 6'h0), 32'h8002_0102, 0, 32'h5000, we, rd, d, multi, wr, mis);
    drive(mk(LW, 5'd6, 5'd0, 6'h0), 32'h8002_0102, 0, 32'h5000, st, wn);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    vectors++;
    if ({bus.misalign, bus.wb_valid, bus.wb_write_enable, st, wn} !== {3'b110, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL misalign_lw: mis/v/we %b stall %0d wren %0d want 110 0 0",
               {bus.misalign, bus.wb_valid, bus.wb_write_enable}, st, wn);
    end
    @(negedge clock);
    vectors++;
    if (bus.misalign !== 1'b0) begin
      miscompares++; $display("FAIL misalign_pulse: got %b want 0", bus.misalign);
    end
`else
    vectors++;
    if ({bus.wb_valid, bus.wb_write_enable, bus.wb_data, st} !== {2'b11, 32'h11F2_3344, 32'd1}) begin
      miscompares++;
      $display("FAIL truncate_lw: v/we %b data %h stall %0d want 11 11f23344 1",
               {bus.wb_valid, bus.wb_write_enable}, bus.wb_data, st);
    end
`endif
  endtask

  task automatic test_reset_mid_rmw();
    load_word(32'h8002_0108, 32'hCAFE_F00D);
    bus.insn_valid = 1; bus.insn = mk(SB, 5'd3, 5'd0, 6'h0);
    bus.alu_result = 32'h8002_0109; bus.rt_data = 32'h55; bus.pc = 32'h6000;
    @(negedge clock);
    vectors++;
    if (bus.mem_wren !== 1'b1) begin
      miscompares++; $display("FAIL rmw_enter: wren %b want 1", bus.mem_wren);
    end
    bus.insn_valid = 0; reset = 1;
    #1;
    vectors++;
    if ({bus.mem_wren, bus.stall, bus.wb_valid, bus.wb_write_enable, bus.wb_rd, bus.wb_data, bus.pc_out} !== 73'd0) begin
      miscompares++;
      $display("FAIL rmw_reset: wren %b stall %b v %b we %b rd %0d data %h pc %h want all 0", bus.mem_wren,
               bus.stall, bus.wb_valid, bus.wb_write_enable, bus.wb_rd, bus.wb_data, bus.pc_out);
    end
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    vectors++;
    if ({mem[2], bus.wb_valid} !== {32'hCAFE_F00D, 1'b0}) begin
      miscompares++;
      $display("FAIL rmw_abort: word %h v %b want cafef00d 0", mem[2], bus.wb_valid);
    end
  endtask

  task automatic test_random(input int n);
    bit we, multi, mis; bit [4:0] rd; bit [0:31] d, insn, alu, rtd, pc; int wr, st, wn, w0, k;
    bit [5:0] op, fn;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 13);
      fn = 6'h21;
      case (k)
        0: op = LB;  1: op = LH;  2: op = LW;  3: op = LBU;  4: op = LHU;
        5: op = SB;  6: op = SH;  7: op = SW;
        8: begin op = 6'h00; fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'h21; end
        9: op = 6'(8 + $urandom_range(0, 7));
        10: op = 6'h03;
        11: op = 6'h04;
        12: op = 6'h02;
        default: op = 6'h3F;
      endcase
      insn = mk(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), fn);
      alu  = (k <= 7) ? 32'h8002_0100 + $urandom_range(0, 31) : $urandom;
      rtd  = $urandom;
      pc   = $urandom & 32'hFFFF_FFFC;
      model(insn, alu, rtd, pc, we, rd, d, multi, wr, mis);
      w0 = wr_cnt;
      drive(insn, alu, rtd, pc, st, wn);
      vectors++;
      if (st != int'(multi) || wr_cnt - w0 != wr || wn != wr || bus.wb_valid !== 1'b1 ||
          bus.wb_write_enable !== we || bus.pc_out !== pc || (we && (bus.wb_rd !== rd || bus.wb_data !== d))) begin
        miscompares++;
        $display("FAIL rand_%0d op %h: stall %0d writes %0d v %b we %b rd %0d data %h pc %h want %0d %0d 1 %b %0d %h %h",
                 i, op, st, wr_cnt - w0, bus.wb_valid, bus.wb_write_enable, bus.wb_rd, bus.wb_data,
                 bus.pc_out, multi, wr, we, rd, d, pc);
      end
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      vectors++;
      if (bus.misalign !== mis) begin
        miscompares++; $display("FAIL rand_mis_%0d: got %b want %b", i, bus.misalign, mis);
      end
`endif
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clock);
        vectors++;
        if (bus.wb_valid !== 1'b0) begin
          miscompares++; $display("FAIL rand_gap_%0d: wb_valid %b want 0", i, bus.wb_valid);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (mem[i] !== mmem[i]) begin
        miscompares++; $display("FAIL mem_image_%0d: got %h want %h", i, mem[i], mmem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_store();
    test_back_to_back();
    test_idle();
    test_misalign_cfg();
    test_reset_mid_rmw();
    test_random(400);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
